// File: rtl/colour_sensor_emulator.sv
// TCS3200-style colour sensor device model: decodes S0..S3 and produces a 50%-duty
// square wave whose half-period is the selected channel's programmed value times the scaling.
module colour_sensor_emulator #(
  parameter int HALF_W    = 16,
  parameter int MUL_2PCT  = 50,
  parameter int MUL_20PCT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S0,
  input  logic              S1,
  input  logic              S2,
  input  logic              S3,
  input  logic [HALF_W-1:0] red_half,
  input  logic [HALF_W-1:0] blue_half,
  input  logic [HALF_W-1:0] clear_half,
  input  logic [HALF_W-1:0] green_half,
  output logic              signal,
  output logic [1:0]        active_filter,
  output logic              powered
);

  localparam int EFF_W = HALF_W + 6;

  typedef enum logic [1:0] {
    SCALE_OFF   = 2'b00,
    SCALE_2PCT  = 2'b01,
    SCALE_20PCT = 2'b10,
    SCALE_FULL  = 2'b11
  } scale_e;

  logic [3:0]       sel_d;
  logic [3:0]       sel_q;
  logic [HALF_W-1:0] half_sel;
  logic [5:0]       mul;
  logic [EFF_W-1:0] eff;
  logic [EFF_W-1:0] cnt;
  logic [EFF_W-1:0] per;

  assign sel_d = {S0, S1, S2, S3};

  // The effective half-period follows the live pins so a new selection loads its
  // own period on the very edge it is registered.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    half_sel = red_half;
    mul      = '0;
    case (sel_d[1:0])
      2'b00: half_sel = red_half;
      2'b01: half_sel = blue_half;
      2'b10: half_sel = clear_half;
      2'b11: half_sel = green_half;
      default: half_sel = red_half;
    endcase
    case (scale_e'(sel_d[3:2]))
      SCALE_OFF:   mul = '0;
      SCALE_2PCT:  mul = 6'(MUL_2PCT);
      SCALE_20PCT: mul = 6'(MUL_20PCT);
      SCALE_FULL:  mul = 6'd1;
      default:     mul = '0;
    endcase
  end

  assign eff = {6'b0, half_sel} * {{(EFF_W-6){1'b0}}, mul};

  // Priority: reset, selection change, power-down, zero period, wrap, count.
  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      signal <= 1'b0;
      cnt    <= '0;
      per    <= '0;
    end else if (sel_d != sel_q) begin
      sel_q <= sel_d;
      cnt   <= '0;
      per   <= eff;
    end else if (scale_e'(sel_q[3:2]) == SCALE_OFF) begin
      signal <= 1'b0;
      cnt    <= '0;
      per    <= eff;
    end else if (per == '0 || eff == '0) begin
      cnt <= '0;
      per <= eff;
    end else if (cnt == per - EFF_W'(1)) begin
      // Period is latched only at the wrap so *_half edits never cut a half short.
      signal <= ~signal;
      cnt    <= '0;
      per    <= eff;
    end else begin
      cnt <= cnt + EFF_W'(1);
    end
  end

  assign active_filter = sel_q[1:0];
  assign powered       = (sel_q[3:2] != 2'b00);

endmodule

// File: tb/tb_colour_sensor_emulator.sv
// Directed bench for colour_sensor_emulator: expected toggle events are queued by the
// stimulus and matched by an independent monitor against observed output edges.
module tb_colour_sensor_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        S0, S1, S2, S3;
  logic [15:0] red_half, blue_half, clear_half, green_half;
  logic        signal;
  logic [1:0]  active_filter;
  logic        powered;

  colour_sensor_emulator dut (
    .clk           (clk),
    .rst           (rst),
    .S0            (S0),
    .S1            (S1),
    .S2            (S2),
    .S3            (S3),
    .red_half      (red_half),
    .blue_half     (blue_half),
    .clear_half    (clear_half),
    .green_half    (green_half),
    .signal        (signal),
    .active_filter (active_filter),
    .powered       (powered)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        lvl;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned edge_cnt = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic l);
    exp_t e;
    e.cyc = c;
    e.lvl = l;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every observed edge of signal must match the next queued expectation.
  initial begin : monitor
    logic prev_sig;
    exp_t e;
    prev_sig = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && signal !== prev_sig) begin
        edge_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_toggle: got level %b at cycle %0d expected no toggle", signal, cyc);
        end else begin
          e = sb.pop_front();
          check("toggle_cycle", cyc, e.cyc);
          check("toggle_level", 32'(signal), 32'(e.lvl));
        end
      end
      prev_sig = signal;
    end
  end

  initial begin : stimulus
    int unsigned c0, d0, e0, f0, g0, h0, i0, j0;
    rst = 1'b1;
    {S0, S1, S2, S3} = 4'b0000;
    red_half = 16'd4;
    blue_half = 16'd0;
    clear_half = 16'd0;
    green_half = 16'd0;
    @(negedge clk);
    wait_to(3);
    check("rst_signal", 32'(signal), 0);
    check("rst_filter", 32'(active_filter), 0);
    check("rst_powered", 32'(powered), 0);
    mon_en = 1'b1;

    // Red at 100%: half-period 4, then red_half 4->8 mid-half.
    rst = 1'b0;
    {S0, S1, S2, S3} = 4'b1100;
    c0 = cyc + 1;
    push(c0 + 4, 1'b1);
    push(c0 + 8, 1'b0);
    push(c0 + 12, 1'b1);
    push(c0 + 16, 1'b0);
    wait_to(c0);
    check("red_filter", 32'(active_filter), 0);
    check("red_powered", 32'(powered), 1);
    check("red_signal_start", 32'(signal), 0);
    wait_to(c0 + 18);
    red_half = 16'd8;
    push(c0 + 20, 1'b1);
    push(c0 + 28, 1'b0);
    push(c0 + 36, 1'b1);
    wait_to(c0 + 37);
    check("red_drain", sb.size(), 0);

    // Blue half 10, then switch to clear (6) with cnt=7.
    blue_half = 16'd10;
    clear_half = 16'd6;
    {S2, S3} = 2'b01;
    d0 = cyc + 1;
    push(d0 + 10, 1'b0);
    push(d0 + 20, 1'b1);
    wait_to(d0 + 27);
    {S2, S3} = 2'b10;
    e0 = d0 + 28;
    push(e0 + 6, 1'b0);
    push(e0 + 12, 1'b1);
    wait_to(e0);
    check("switch_level_kept", 32'(signal), 1);
    check("switch_filter", 32'(active_filter), 2);
    wait_to(e0 + 13);
    check("switch_drain", sb.size(), 0);

    // Power-down while high, then resume at 100% on clear (6).
    {S0, S1} = 2'b00;
    f0 = cyc + 1;
    push(f0 + 1, 1'b0);
    wait_to(f0);
    check("pd_powered", 32'(powered), 0);
    check("pd_level_kept", 32'(signal), 1);
    wait_to(f0 + 1);
    check("pd_signal_low", 32'(signal), 0);
    wait_to(f0 + 4);
    {S0, S1} = 2'b11;
    g0 = f0 + 5;
    push(g0 + 6, 1'b1);
    push(g0 + 12, 1'b0);
    wait_to(g0);
    check("resume_powered", 32'(powered), 1);
    wait_to(g0 + 13);
    check("resume_drain", sb.size(), 0);

    // 20% scaling on green (3): toggles every 15, 20 edges in 300 cycles.
    green_half = 16'd3;
    {S0, S1, S2, S3} = 4'b1011;
    h0 = cyc + 1;
    edge_cnt = 0;
    for (int k = 1; k <= 20; k++) push(h0 + 15 * k, (k % 2) == 1);
    wait_to(h0 + 301);
    check("scale20_edges", edge_cnt, 20);
    check("scale20_filter", 32'(active_filter), 3);
    check("scale20_drain", sb.size(), 0);

    // Zero period on red, then program 2, then 4 for the following half.
    red_half = 16'd0;
    {S0, S1, S2, S3} = 4'b1100;
    i0 = cyc + 1;
    wait_to(i0 + 5);
    check("zero_held", 32'(signal), 0);
    red_half = 16'd2;
    push(i0 + 8, 1'b1);
    push(i0 + 10, 1'b0);
    push(i0 + 12, 1'b1);
    wait_to(i0 + 11);
    red_half = 16'd4;

    // Reset while high with cnt=2, then release into red (4).
    wait_to(i0 + 14);
    rst = 1'b1;
    push(i0 + 15, 1'b0);
    wait_to(i0 + 15);
    check("rst_mid_signal", 32'(signal), 0);
    check("rst_mid_filter", 32'(active_filter), 0);
    check("rst_mid_powered", 32'(powered), 0);
    wait_to(i0 + 17);
    rst = 1'b0;
    j0 = i0 + 18;
    push(j0 + 4, 1'b1);
    wait_to(j0 + 5);
    check("final_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
